// File: rtl/sr_pkg.sv
// Shared types and limits for the SR flip-flop drive controller.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    RECOV = 2'd2
  } sr_state_t;

  localparam int SR_CNT_W = 4;

  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = 15;
  localparam int RECOV_W_MIN = 0;
  localparam int RECOV_W_MAX = 15;

endpackage

// File: rtl/sr_drive_ctrl.sv
// Turns level requests into timed, never-overlapping set/reset pulses.
// Optional readback check of the driven flop is enabled by SR_READBACK_CHECK_EN.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int RECOV_W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic busy,
  output logic cur_val,
  output logic cur_known
`ifdef SR_READBACK_CHECK_EN
  ,
  input  logic q_fb,
  output logic fb_err
`endif
);

  if (PULSE_W < PULSE_W_MIN || PULSE_W > PULSE_W_MAX) begin : g_bad_pulse_w
    $error("sr_drive_ctrl: PULSE_W out of range");
  end
  if (RECOV_W < RECOV_W_MIN || RECOV_W > RECOV_W_MAX) begin : g_bad_recov_w
    $error("sr_drive_ctrl: RECOV_W out of range");
  end

  localparam logic [SR_CNT_W-1:0] PULSE_LAST = SR_CNT_W'(PULSE_W - 1);
  localparam logic [SR_CNT_W-1:0] RECOV_LAST = SR_CNT_W'((RECOV_W > 0) ? RECOV_W - 1 : 0);

  sr_state_t           state_q, state_d;
  logic [SR_CNT_W-1:0] cnt_q, cnt_d;
  logic                val_q, val_d;
  logic                s_q, s_d;
  logic                r_q, r_d;
  logic                cur_val_q, cur_val_d;
  logic                cur_known_q, cur_known_d;
  logic                drive;
  logic                drive_val;
  logic                xfer;
  logic                redundant;

  assign xfer      = req_valid && (state_q == IDLE);
  assign redundant = cur_known_q && (req_val == cur_val_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    val_d       = val_q;
    cur_val_d   = cur_val_q;
    cur_known_d = cur_known_q;
    drive       = 1'b0;
    drive_val   = val_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && !redundant) begin
          state_d   = PULSE;
          val_d     = req_val;
          drive     = 1'b1;
          drive_val = req_val;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d       = '0;
          cur_val_d   = val_q;
          cur_known_d = 1'b1;
          state_d     = (RECOV_W > 0) ? RECOV : IDLE;
        end else begin
          drive = 1'b1;
        end
      end
      RECOV: begin
        if (cnt_q == RECOV_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Both pulse lines come from one level, so they can never be high together.
    s_d = drive & drive_val;
    r_d = drive & ~drive_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      val_q       <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      cur_val_q   <= 1'b0;
      cur_known_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      s_q         <= s_d;
      r_q         <= r_d;
      cur_val_q   <= cur_val_d;
      cur_known_q <= cur_known_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign cur_val   = cur_val_q;
  assign cur_known = cur_known_q;

`ifdef SR_READBACK_CHECK_EN
  logic post_q, post_d;
  logic fb_err_q, fb_err_d;
  logic fb_hit;

  // The mismatch shows on fb_err in the checked cycle itself, then latches.
  always_comb begin
    post_d   = (state_q == PULSE) && (cnt_q == PULSE_LAST);
    fb_hit   = post_q && (q_fb != cur_val_q);
    fb_err_d = fb_err_q | fb_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_q   <= 1'b0;
      fb_err_q <= 1'b0;
    end else begin
      post_q   <= post_d;
      fb_err_q <= fb_err_d;
    end
  end

  assign fb_err = fb_err_d;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Scoreboard bench for sr_drive_ctrl: two parameter sets under random traffic,
// plus a tied-low readback instance when SR_READBACK_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_sr_drive_ctrl;

  localparam int N_INST = 2;

  typedef struct {
    logic val;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
    localparam int PW = (gi == 0) ? 2 : 1;
    localparam int RW = (gi == 0) ? 1 : 0;

    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic req_ready, s, r, busy, cur_val, cur_known;
    logic done = 1'b0;

    exp_t q[$];
    logic m_known = 1'b0;
    logic m_cur = 1'b0;
    int   ready_at = 0;

`ifdef SR_READBACK_CHECK_EN
    logic fb_err;
    logic q_ff = 1'b0;
    always @(posedge clk) begin
      if (s) q_ff <= 1'b1;
      else if (r) q_ff <= 1'b0;
    end
`endif

    sr_drive_ctrl #(.PULSE_W(PW), .RECOV_W(RW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_val   (req_val),
      .req_ready (req_ready),
      .s         (s),
      .r         (r),
      .busy      (busy),
      .cur_val   (cur_val),
      .cur_known (cur_known)
`ifdef SR_READBACK_CHECK_EN
      ,
      .q_fb      (q_ff),
      .fb_err    (fb_err)
`endif
    );

    function automatic string nm(input string base);
      return $sformatf("u%0d_%s", gi, base);
    endfunction

    // Reference model: a request changes the stored value only if it differs
    // from a known shadow; each change costs PW pulse + RW gap cycles.
    task automatic model_xfer(input logic v);
      if (m_known && v == m_cur) begin
        $display("u%0d xfer t=%0t val=%0d redundant", gi, $time, v);
      end else begin
        q.push_back('{val: v, acc: cyc + 1});
        ready_at = cyc + 1 + PW + RW;
        m_cur    = v;
        m_known  = 1'b1;
        $display("u%0d xfer t=%0t val=%0d pulse", gi, $time, v);
      end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    // with req_valid still high so the caller may chain another request.
    task automatic req(input logic v);
      int guard = 0;
      req_valid = 1'b1;
      req_val   = v;
      while (!req_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      chk(nm("ready_within_budget"), int'(req_ready), 1);
      if (req_ready) model_xfer(v);
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic do_rst(input logic with_req, input logic v);
      rst       = 1'b1;
      req_valid = with_req;
      req_val   = v;
      q.delete();
      m_known   = 1'b0;
      m_cur     = 1'b0;
      ready_at  = 0;
      $display("u%0d reset t=%0t with_req=%0d", gi, $time, with_req);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
    endtask

    initial begin : stim
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2);
      // set, redundant set, reset
      req(1'b1); idle(PW + RW + 1);
      req(1'b1); idle(1);
      req(1'b0); idle(PW + RW + 1);
      // back-to-back alternating with valid held high
      req(1'b1); req(1'b0); req(1'b1); req(1'b0); idle(PW + RW + 1);
      // reset in the second pulse cycle of a reset pulse
      req(1'b1); idle(PW + RW + 1);
      req(1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      do_rst(1'b0, 1'b0);
      idle(1);
      req(1'b0); idle(PW + RW + 1);
      // request coinciding with reset is dropped
      do_rst(1'b1, 1'b1);
      idle(1);
      req(1'b1); idle(PW + RW + 1);
      // random traffic
      repeat (150) begin
        if ($urandom_range(19) == 0)
          do_rst(1'($urandom_range(1)), 1'($urandom_range(1)));
        else if ($urandom_range(3) != 0)
          req(1'($urandom_range(1)));
        else
          idle($urandom_range(3, 1));
      end
      idle(PW + RW + 4);
      chk(nm("scoreboard_drained"), q.size(), 0);
      done = 1'b1;
    end

    initial begin : mon
      bit   in_p = 1'b0;
      logic pv = 1'b0;
      int   w = 0;
      exp_t ex;
      forever begin
        @(posedge clk);
        #1;
        chk(nm("s_and_r_exclusive"), int'(s & r), 0);
        chk(nm("busy_vs_ready"), int'(busy), int'(!req_ready));
        if (rst) begin
          chk(nm("rst_s"), int'(s), 0);
          chk(nm("rst_r"), int'(r), 0);
          chk(nm("rst_ready"), int'(req_ready), 1);
          chk(nm("rst_cur_val"), int'(cur_val), 0);
          chk(nm("rst_cur_known"), int'(cur_known), 0);
`ifdef SR_READBACK_CHECK_EN
          chk(nm("rst_fb_err"), int'(fb_err), 0);
`endif
          in_p = 1'b0;
        end else begin
          chk(nm("req_ready"), int'(req_ready), int'(cyc >= ready_at));
          if (s || r) begin
            if (!in_p) begin
              chk(nm("pulse_has_expectation"), int'(q.size() > 0), 1);
              pv = s;
              if (q.size() > 0) begin
                ex = q.pop_front();
                chk(nm("pulse_start_cycle"), cyc, ex.acc);
                chk(nm("pulse_s"), int'(s), int'(ex.val));
                chk(nm("pulse_r"), int'(r), int'(!ex.val));
                pv = ex.val;
              end
              in_p = 1'b1;
              w    = 1;
            end else begin
              w++;
              chk(nm("pulse_level_steady"), int'(s), int'(pv));
            end
          end else if (in_p) begin
            in_p = 1'b0;
            chk(nm("pulse_width"), w, PW);
            chk(nm("cur_val_after_pulse"), int'(cur_val), int'(pv));
            chk(nm("cur_known_after_pulse"), int'(cur_known), 1);
`ifdef SR_READBACK_CHECK_EN
            chk(nm("fb_err_with_flop"), int'(fb_err), 0);
`endif
          end
        end
      end
    end
  end

`ifdef SR_READBACK_CHECK_EN
  logic f_rst = 1'b1;
  logic f_valid = 1'b0;
  logic f_val = 1'b0;
  logic f_ready, f_s, f_r, f_busy, f_cur_val, f_cur_known, f_err;
  logic f_done = 1'b0;

  sr_drive_ctrl #(.PULSE_W(2), .RECOV_W(1)) u_fb (
    .clk       (clk),
    .rst       (f_rst),
    .req_valid (f_valid),
    .req_val   (f_val),
    .req_ready (f_ready),
    .s         (f_s),
    .r         (f_r),
    .busy      (f_busy),
    .cur_val   (f_cur_val),
    .cur_known (f_cur_known),
    .q_fb      (1'b0),
    .fb_err    (f_err)
  );

  initial begin : fb_stim
    repeat (2) @(negedge clk);
    f_rst = 1'b0;
    @(negedge clk);
    chk("fb_ready_after_rst", int'(f_ready), 1);
    f_valid = 1'b1;
    f_val   = 1'b1;
    $display("fb xfer t=%0t val=1 pulse", $time);
    @(negedge clk);
    f_valid = 1'b0;
    chk("fb_err_pulse_cycle0", int'(f_err), 0);
    @(negedge clk);
    chk("fb_err_pulse_cycle1", int'(f_err), 0);
    @(negedge clk);
    chk("fb_err_first_post_cycle", int'(f_err), 1);
    @(negedge clk);
    chk("fb_ready_after_recov", int'(f_ready), 1);
    f_valid = 1'b1;
    f_val   = 1'b0;
    $display("fb xfer t=%0t val=0 pulse", $time);
    @(negedge clk);
    f_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("fb_err_sticky", int'(f_err), 1);
    f_rst = 1'b1;
    @(negedge clk);
    f_rst = 1'b0;
    chk("fb_err_cleared_by_rst", int'(f_err), 0);
    f_done = 1'b1;
  end
`endif

  initial begin : finisher
    int   guard = 0;
    logic all_done;
    all_done = 1'b0;
    while (!all_done && guard < 20000) begin
      @(posedge clk);
      guard++;
      all_done = g_inst[0].done && g_inst[1].done;
`ifdef SR_READBACK_CHECK_EN
      all_done = all_done && f_done;
`endif
    end
    chk("stimulus_completed", int'(all_done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
